// File: rtl/dcache_axi_wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_wb_master_pkg
// Description : Shared configuration and AXI encodings for the dcache
//               write-back master: line/data widths, burst and response
//               codes, the write-back FSM state type and an AWSIZE helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_axi_wb_master_pkg;

    // Core configuration
    localparam int DCACHELINE_WIDTH = 128;
    localparam int AXI_DATA_WIDTH   = 32;
    localparam int AXI_ADDR_WIDTH   = 32;

    // AXI encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Write-back FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wb_state_t;

    // AWSIZE encoding for a beat of 'bytes' bytes (log2 of the byte count)
    function automatic logic [2:0] axi_size_enc(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_axi_wb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_wb_master_if
// Description : AXI4 write-channel bundle (AW, W, B) between the dcache
//               write-back master and the crossbar port. Signal suffixes
//               are from the master's point of view.
// Ports       : master modport drives AW/W valid+payload and B ready;
//               slave modport drives AW/W ready and B valid/resp/id.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_axi_wb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // AW channel
    logic                  awvalid_o;
    logic                  awready_i;
    logic [ADDR_W-1:0]     awaddr_o;
    logic [7:0]            awlen_o;
    logic [2:0]            awsize_o;
    logic [1:0]            awburst_o;
    logic [3:0]            awid_o;
    // W channel
    logic                  wvalid_o;
    logic                  wready_i;
    logic [DATA_W-1:0]     wdata_o;
    logic [DATA_W/8-1:0]   wstrb_o;
    logic                  wlast_o;
    // B channel
    logic                  bvalid_i;
    logic                  bready_o;
    logic [1:0]            bresp_i;
    logic [3:0]            bid_i;

    modport master (
        output awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awid_o,
        input  awready_i,
        output wvalid_o, wdata_o, wstrb_o, wlast_o,
        input  wready_i,
        input  bvalid_i, bresp_i, bid_i,
        output bready_o
    );

    modport slave (
        input  awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awid_o,
        output awready_i,
        input  wvalid_o, wdata_o, wstrb_o, wlast_o,
        output wready_i,
        output bvalid_i, bresp_i, bid_i,
        input  bready_o
    );

endinterface
`default_nettype wire

// File: rtl/dcache_axi_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : dcache_axi_wb_master
// Description : AXI4 write-burst master draining the dcache write-back FIFO.
//               Latches one cache line per request and issues a single INCR
//               burst: AW, then BEATS W beats (LSB beat first), then B.
// Ports       : clk, rst (async, active-low)
//               req_i/req_addr_i/req_data_i  : line offered by the FIFO
//               req_accept_o                 : 1-cycle pulse, line latched
//               done_o                       : 1-cycle pulse, B received
//               busy_o                       : transaction in flight
//               err_o                        : sticky non-OKAY BRESP seen
//               axi                          : AW/W/B master modport
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_axi_wb_master
    import dcache_axi_wb_master_pkg::*;
#(
    parameter int         LINE_W = DCACHELINE_WIDTH,
    parameter int         DATA_W = AXI_DATA_WIDTH,
    parameter int         ADDR_W = AXI_ADDR_WIDTH,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              req_i,
    input  wire logic [ADDR_W-1:0] req_addr_i,
    input  wire logic [LINE_W-1:0] req_data_i,
    output logic                   req_accept_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   err_o,
    dcache_axi_wb_master_if.master axi
);

    localparam int BEATS = LINE_W / DATA_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
    // Clears the byte offset within a line so the burst starts line-aligned
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    wb_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;

    logic              w_latch;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_bready;
    logic              w_accept;
    logic              w_done;
    logic [DATA_W-1:0] w_beat [BEATS];

    // ------------------------------------------------------------------
    // State, beat counter and sticky error (reset-cleared)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Line buffer: contents are irrelevant until a request is latched
    always_ff @(posedge clk) begin
        if (w_latch) begin
            addr_q <= req_addr_i;
            line_q <= req_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        w_latch   = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                w_accept = req_i;
                if (req_i) begin
                    w_latch = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                w_awvalid = 1'b1;
                if (axi.awready_i) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                w_wvalid = 1'b1;
                if (axi.wready_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        // Counter returns to zero only as DATA is left
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESP: begin
                // An early bvalid waits here; it is only acknowledged now
                w_bready = 1'b1;
                if (axi.bvalid_i) begin
                    w_done  = 1'b1;
                    err_d   = err_q | (axi.bresp_i != AXI_RESP_OKAY);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat view of the line buffer: beat 0 holds the least significant bits
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign w_beat[gi] = line_q[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_accept_o  = w_accept;
    assign done_o        = w_done;
    assign busy_o        = (state_q != IDLE);
    assign err_o         = err_q;

    assign axi.awvalid_o = w_awvalid;
    assign axi.awaddr_o  = addr_q & ADDR_MASK;
    assign axi.awlen_o   = 8'(BEATS - 1);
    assign axi.awsize_o  = axi_size_enc(DATA_W / 8);
    assign axi.awburst_o = AXI_BURST_INCR;
    assign axi.awid_o    = AXI_ID;

    assign axi.wvalid_o  = w_wvalid;
    assign axi.wdata_o   = w_beat[cnt_q];
    assign axi.wstrb_o   = '1;
    assign axi.wlast_o   = w_wvalid & (cnt_q == LAST_BEAT);

    assign axi.bready_o  = w_bready;

endmodule
`default_nettype wire

// File: tb/tb_dcache_axi_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_axi_wb_master
// Description : Self-checking bench for dcache_axi_wb_master. A queue-based
//               FIFO feeds lines; a slave model drives AW/W/B readiness with
//               configurable stalls; a monitor compares every handshake
//               against a transaction-level reference (expected line queue).
// Ports       : none (testbench top)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_axi_wb_master;
    import dcache_axi_wb_master_pkg::*;

    localparam int LINE_W = 128;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / DATA_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } line_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [LINE_W-1:0] req_data_i;
    logic              req_accept_o;
    logic              done_o;
    logic              busy_o;
    logic              err_o;

    dcache_axi_wb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    dcache_axi_wb_master #(
        .LINE_W (LINE_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .AXI_ID (4'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_accept_o (req_accept_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus-side state (owned by the main process)
    // ------------------------------------------------------------------
    line_t fifo[$];
    int    aw_delay  = 0;
    bit    aw_rand   = 1'b0;
    int    aw_cnt    = 0;
    int    w_mode    = 0;     // 0 always ready, 1 toggle, 2 random
    int    b_mode    = 0;     // 0 after last beat, 1 raised early during W, 2 random delay
    logic [1:0] bresp_v = 2'b00;
    bit    b_pend    = 1'b0;
    bit    exact_span = 1'b0;
    int    pops      = 0;
    int    w_hs      = 0;

    // ------------------------------------------------------------------
    // Reference model / monitor state (owned by the monitor)
    // ------------------------------------------------------------------
    line_t             exp_q[$];
    bit                busy_m    = 1'b0;
    bit                aw_done_m = 1'b0;
    int                beat_m    = 0;
    bit                err_exp   = 1'b0;
    int                done_cnt  = 0;
    int                cyc       = 0;
    int                acc_cyc   = 0;
    bit                prev_awpend = 1'b0;
    logic [48:0]       prev_aw;
    bit                prev_wpend  = 1'b0;
    logic [36:0]       prev_w;
    logic [LINE_W-1:0] line_sh;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            busy_m      = 1'b0;
            aw_done_m   = 1'b0;
            beat_m      = 0;
            err_exp     = 1'b0;
            prev_awpend = 1'b0;
            prev_wpend  = 1'b0;
        end else begin
            check_val("busy", 128'(busy_o), 128'(busy_m));
            if (req_accept_o || done_o)
                check_val("acc_done_excl", 128'(req_accept_o & done_o), 128'd0);
            if (axi.awvalid_o || axi.wvalid_o)
                check_val("aw_w_excl", 128'(axi.awvalid_o & axi.wvalid_o), 128'd0);

            if (prev_awpend)
                check_val("aw_stable",
                          128'({axi.awvalid_o, axi.awaddr_o, axi.awlen_o, axi.awsize_o, axi.awburst_o, axi.awid_o}),
                          128'({1'b1, prev_aw}));
            prev_awpend = axi.awvalid_o & ~axi.awready_i;
            prev_aw     = {axi.awaddr_o, axi.awlen_o, axi.awsize_o, axi.awburst_o, axi.awid_o};

            if (prev_wpend)
                check_val("w_stable", 128'({axi.wvalid_o, axi.wdata_o, axi.wstrb_o, axi.wlast_o}),
                          128'({1'b1, prev_w}));
            prev_wpend = axi.wvalid_o & ~axi.wready_i;
            prev_w     = {axi.wdata_o, axi.wstrb_o, axi.wlast_o};

            // A response offered before all beats are sent must not be taken
            if (axi.bvalid_i && busy_m && beat_m < BEATS)
                check_val("bready_early", 128'(axi.bready_o), 128'd0);

            if (req_accept_o) begin
                check_val("acc_in_idle", 128'(busy_m), 128'd0);
                exp_q.push_back('{req_addr_i, req_data_i});
                acc_cyc   = cyc;
                busy_m    = 1'b1;
                aw_done_m = 1'b0;
                beat_m    = 0;
            end

            if (axi.awvalid_o && axi.awready_i) begin
                check_val("aw_once", 128'(aw_done_m), 128'd0);
                if (exp_q.size() == 0) begin
                    check_val("aw_unexpected", 128'd1, 128'd0);
                end else begin
                    check_val("awaddr", 128'(axi.awaddr_o), 128'({exp_q[0].addr[31:4], 4'h0}));
                end
                check_val("aw_attr", 128'({axi.awlen_o, axi.awsize_o, axi.awburst_o, axi.awid_o}),
                          128'({8'd3, 3'd2, 2'b01, 4'd1}));
                aw_done_m = 1'b1;
            end

            if (axi.wvalid_o && axi.wready_i) begin
                check_val("w_after_aw", 128'(aw_done_m), 128'd1);
                check_val("w_beat_range", 128'(beat_m < BEATS), 128'd1);
                if (exp_q.size() > 0) begin
                    line_sh = exp_q[0].data >> (DATA_W * beat_m);
                    check_val("wdata", 128'(axi.wdata_o), 128'(line_sh[DATA_W-1:0]));
                end
                check_val("wlast", 128'(axi.wlast_o), 128'(beat_m == BEATS - 1));
                check_val("wstrb", 128'(axi.wstrb_o), 128'hF);
                beat_m++;
            end

            if (done_o) begin
                check_val("done_beats", 128'(beat_m), 128'(BEATS));
                check_val("err_before_done", 128'(err_o), 128'(err_exp));
                if (exact_span)
                    check_val("done_span", 128'(cyc - acc_cyc + 1), 128'd7);
                else
                    check_val("done_min_lag", 128'(cyc - acc_cyc >= 3), 128'd1);
                if (axi.bresp_i != 2'b00)
                    err_exp = 1'b1;
                if (exp_q.size() > 0)
                    void'(exp_q.pop_front());
                done_cnt++;
                busy_m = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One clock of FIFO + slave behaviour: sample before the edge,
    // drive 1 ns after it.
    // ------------------------------------------------------------------
    task automatic step();
        bit acc_s, wl_s, bh_s, wh_s;
        @(negedge clk);
        acc_s = req_accept_o;
        wh_s  = axi.wvalid_o & axi.wready_i;
        wl_s  = wh_s & axi.wlast_o;
        bh_s  = axi.bvalid_i & axi.bready_o;
        @(posedge clk);
        #1;
        if (acc_s && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        if (wh_s) w_hs++;
        if (bh_s) b_pend = 1'b0;
        if (wl_s) b_pend = 1'b1;

        req_i = (fifo.size() > 0);
        if (fifo.size() > 0) begin
            req_addr_i = fifo[0].addr;
            req_data_i = fifo[0].data;
        end

        if (axi.awvalid_o) begin
            axi.awready_i = aw_rand ? 1'($urandom_range(0, 1)) : (aw_cnt >= aw_delay);
            aw_cnt++;
        end else begin
            aw_cnt = 0;
            axi.awready_i = aw_rand ? 1'($urandom_range(0, 1)) : (aw_delay == 0);
        end

        case (w_mode)
            0:       axi.wready_i = 1'b1;
            1:       axi.wready_i = ~axi.wready_i;
            default: axi.wready_i = 1'($urandom_range(0, 1));
        endcase

        case (b_mode)
            0:       axi.bvalid_i = b_pend;
            1:       axi.bvalid_i = b_pend | axi.wvalid_o;
            default: axi.bvalid_i = b_pend & (axi.bvalid_i | 1'($urandom_range(0, 1)));
        endcase
        axi.bresp_i = bresp_v;
        axi.bid_i   = 4'($urandom_range(0, 15));
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_val("txn_count", 128'(done_cnt), 128'(target));
    endtask

    task automatic push_rand();
        line_t l;
        l.addr = $urandom;
        l.data = {$urandom, $urandom, $urandom, $urandom};
        fifo.push_back(l);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int tgt;
        int pops0;
        req_i         = 1'b0;
        req_addr_i    = '0;
        req_data_i    = '0;
        axi.awready_i = 1'b0;
        axi.wready_i  = 1'b0;
        axi.bvalid_i  = 1'b0;
        axi.bresp_i   = 2'b00;
        axi.bid_i     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs",
                  128'({req_accept_o, done_o, busy_o, err_o, axi.awvalid_o, axi.wvalid_o, axi.bready_o, axi.wlast_o}),
                  128'd0);
        rst = 1'b1;
        step();

        // 1: directed line, everything ready, minimum-length transaction
        exact_span = 1'b1;
        fifo.push_back('{32'h8000_1234, 128'h44444444_33333333_22222222_11111111});
        tgt = done_cnt + 1;
        run_until(tgt, 50);
        exact_span = 1'b0;
        repeat (3) step();
        check_val("t1_single_done", 128'(done_cnt), 128'(tgt));

        // 2: AW stalled 3 cycles, W ready toggling
        aw_delay = 3;
        w_mode   = 1;
        push_rand();
        tgt = done_cnt + 1;
        run_until(tgt, 60);
        repeat (4) step();
        check_val("t2_single_done", 128'(done_cnt), 128'(tgt));

        // 3: bvalid raised during DATA
        aw_delay = 0;
        w_mode   = 2;
        b_mode   = 1;
        push_rand();
        tgt = done_cnt + 1;
        run_until(tgt, 80);
        repeat (4) step();
        check_val("t3_single_done", 128'(done_cnt), 128'(tgt));

        // 4: SLVERR then OKAY; error stays sticky
        b_mode  = 0;
        w_mode  = 0;
        bresp_v = 2'b10;
        push_rand();
        tgt = done_cnt + 1;
        run_until(tgt, 50);
        bresp_v = 2'b00;
        step();
        check_val("t4_err_set", 128'(err_o), 128'd1);
        push_rand();
        tgt = done_cnt + 1;
        run_until(tgt, 50);
        step();
        check_val("t4_err_sticky", 128'(err_o), 128'd1);

        // 5: two queued lines, random slave timing
        aw_rand = 1'b1;
        w_mode  = 2;
        b_mode  = 2;
        pops0   = pops;
        push_rand();
        push_rand();
        tgt = done_cnt + 2;
        run_until(tgt, 200);
        check_val("t5_pops", 128'(pops - pops0), 128'd2);
        check_val("t5_fifo_empty", 128'(fifo.size()), 128'd0);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            aw_rand  = 1'($urandom_range(0, 1));
            aw_delay = $urandom_range(0, 2);
            w_mode   = $urandom_range(0, 2);
            b_mode   = $urandom_range(0, 2);
            bresp_v  = 2'($urandom_range(0, 3));
            tgt = done_cnt + 1;
            push_rand();
            if ($urandom_range(0, 1) == 1) begin
                push_rand();
                tgt++;
            end
            run_until(tgt, 200);
        end
        bresp_v = 2'b00;
        step();
        check_val("err_final", 128'(err_o), 128'(err_exp));

        // 6: reset while presenting beat 2, then a clean full burst
        aw_rand  = 1'b0;
        aw_delay = 0;
        w_mode   = 0;
        b_mode   = 0;
        w_hs     = 0;
        push_rand();
        for (int n = 0; n < 40 && w_hs < 2; n++) step();
        check_val("t6_reached_beat2", 128'(w_hs), 128'd2);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_async_reset_outs",
                  128'({req_accept_o, done_o, busy_o, err_o, axi.awvalid_o, axi.wvalid_o, axi.bready_o, axi.wlast_o}),
                  128'd0);
        fifo.delete();
        b_pend        = 1'b0;
        req_i         = 1'b0;
        axi.bvalid_i  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        tgt = done_cnt + 1;
        push_rand();
        run_until(tgt, 50);
        step();
        check_val("t6_err_after_reset", 128'(err_o), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
